// File: rtl/find_prime_pkg.sv
// find_prime_pkg: shared constants and FSM state type for the prime search stage.
package find_prime_pkg;

  localparam int unsigned WIDTH_DEFAULT = 7;
  localparam int unsigned MIN_PRIME     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prime_div_check.sv
// prime_div_check: combinational trial-division step (divisibility and square bound).
module prime_div_check
  import find_prime_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] div,
  output logic             divides,
  output logic             exceeds
);

  localparam int unsigned SQ_W = 2 * WIDTH;

  logic [SQ_W-1:0] div_sq;

  // Square at double width so the bound compare never overflows.
  assign div_sq  = SQ_W'(div) * SQ_W'(div);
  assign exceeds = div_sq > SQ_W'(cand);

  // div is never zero in TEST; the guard keeps the modulo well defined.
  assign divides = (div != '0) && ((cand % div) == '0);

endmodule

// File: rtl/find_prime.sv
// find_prime: finds the smallest prime >= seed by trial division, one divisor per clock.
// Optional macro FIND_PRIME_CACHE_EN: remembers the last seed/prime pair and
// answers a repeated seed directly without searching.
module find_prime
  import find_prime_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             findPrimeEnable,
  input  logic [WIDTH-1:0] numberInput,
  output logic [WIDTH-1:0] primeNumberOutput,
  output logic             primeValid,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(MIN_PRIME);
  localparam logic [WIDTH-1:0] CAND_MAX = '1;

  state_t           state, state_next;
  logic [WIDTH-1:0] cand, cand_next;
  logic [WIDTH-1:0] div, div_next;
  logic [WIDTH-1:0] prime_next;
  logic             en_prev;
  logic             start_c;
  logic             divides, exceeds;

  assign start_c = findPrimeEnable & ~en_prev;

  prime_div_check #(.WIDTH(WIDTH)) u_div_check (
    .cand    (cand),
    .div     (div),
    .divides (divides),
    .exceeds (exceeds)
  );

`ifdef FIND_PRIME_CACHE_EN
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] last_seed;
  logic [WIDTH-1:0] last_prime;
  logic             cache_valid;
  logic             cache_hit_c;

  assign cache_hit_c = cache_valid && (numberInput == last_seed);

  // Capture the raw seed of each search and record every completed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed        <= '0;
      last_seed   <= '0;
      last_prime  <= '0;
      cache_valid <= 1'b0;
    end else begin
      if (state == IDLE && start_c) begin
        seed <= numberInput;
      end
      if (state == TEST && exceeds) begin
        last_seed   <= seed;
        last_prime  <= cand;
        cache_valid <= 1'b1;
      end
    end
  end
`endif

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    div_next   = div;
    prime_next = primeNumberOutput;
    unique case (state)
      IDLE: begin
        if (start_c) begin
          cand_next  = (numberInput < MIN_VAL) ? MIN_VAL : numberInput;
          div_next   = MIN_VAL;
          state_next = TEST;
`ifdef FIND_PRIME_CACHE_EN
          if (cache_hit_c) begin
            prime_next = last_prime;
            state_next = DONE;
          end
`endif
        end
      end
      TEST: begin
        if (exceeds) begin
          prime_next = cand;
          state_next = DONE;
        end else if (divides) begin
          // Composite at the top of the range wraps back to the smallest prime.
          cand_next = (cand == CAND_MAX) ? MIN_VAL : cand + WIDTH'(1);
          div_next  = MIN_VAL;
        end else begin
          div_next = div + WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cand              <= '0;
      div               <= '0;
      primeNumberOutput <= '0;
      primeValid        <= 1'b0;
      busy              <= 1'b0;
      en_prev           <= 1'b0;
    end else begin
      state             <= state_next;
      cand              <= cand_next;
      div               <= div_next;
      primeNumberOutput <= prime_next;
      primeValid        <= (state_next == DONE);
      busy              <= (state_next != IDLE);
      en_prev           <= findPrimeEnable;
    end
  end

endmodule

// File: doc/find_prime.md
Name: find_prime

Overview:
- Stage directly downstream of the level-adjust stage.
- Consumes the range-limited 7-bit number and its findPrimeEnable strobe.
- Searches upward for the smallest prime greater than or equal to that number, by iterative trial division (one divisor test per clock).
- Presents the prime with a one-cycle valid pulse to the game/compare logic.

Parameters:
- WIDTH, 7, bit width of the number path (input and output).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- findPrimeEnable  input  1  start request from the level-adjust stage; level signal, rising edge starts a search.
- numberInput  input  WIDTH  search seed, sampled on the accepting edge.
- primeNumberOutput  output  WIDTH  last found prime, registered; held until the next result.
- primeValid  output  1  high for exactly one cycle when primeNumberOutput is updated.
- busy  output  1  high while a search is in progress or completing (TEST, DONE).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; primeNumberOutput=0; primeValid=0; busy=0.
  - Internal cand=0, div=0; start-edge register enPrev=0.
  - Applies mid-search too: the search is abandoned and no result is produced.
- Start detect:
  - enPrev<=findPrimeEnable every cycle.
  - start = findPrimeEnable & ~enPrev.
  - start is acted on only in IDLE; rising edges in TEST or DONE are dropped, not queued.
  - After reset, enable already high counts as a rising edge.
- States:
  - IDLE: busy=0. On start: cand<=max(numberInput,2), so inputs 0 and 1 clamp to 2; div<=2; go TEST.
  - TEST: one step per cycle, busy=1.
    - If div*div > cand: cand is prime; primeNumberOutput<=cand; go DONE.
    - Else if cand mod div == 0: cand<=cand+1, div<=2, stay TEST.
    - Else: div<=div+1, stay TEST.
  - DONE: primeValid=1 (Moore), busy=1; next edge go IDLE unconditionally.
- Arithmetic:
  - div*div is computed at 2*WIDTH bits, so there is no overflow in the compare.
  - mod is on WIDTH bits.
- Wrap-around: if cand == 2^WIDTH-1 and is composite, cand<=2 and div<=2; the search continues and returns 2.
  - Unreachable for WIDTH=7, since 127 is prime.
- Latency: with N TEST steps, primeValid is high in the cycle after N+1 edges following the accepting edge.
  - Seed 2 → N=1, valid after edge 2.
- primeNumberOutput changes only on entry to DONE.

Optional Feature:
- Macro: FIND_PRIME_CACHE_EN.
- Defined:
  - Adds registers lastSeed[WIDTH] and lastPrime[WIDTH], plus a cacheValid bit (cleared by reset).
  - On start with cacheValid and numberInput==lastSeed: go straight to DONE with primeNumberOutput<=lastPrime (valid after 1 edge), skipping TEST.
  - Every completed search updates lastSeed, lastPrime and cacheValid=1.
  - An abandoned search (reset) leaves cacheValid=0.
- Undefined: every start runs a full TEST search; no extra registers.

Decomposition:
- Package find_prime_pkg holds:
  - state enum {IDLE, TEST, DONE};
  - WIDTH default constant;
  - MIN_PRIME=2.
- One combinational sub-module, prime_div_check (inputs cand, div; outputs divides, exceeds), isolates the mod and square compare for reuse and timing.
- FSM and registers stay in find_prime.

Test Plan:
- Reset then seed 7, findPrimeEnable 0→1 → primeNumberOutput=7, primeValid one cycle after 3 edges, busy high for those cycles.
- Seed 8 → output 11 after 8 edges: 7 TEST steps, as 8→9→10 are rejected.
- Seeds 0 and 1 → output 2 after 2 edges; seed 99 → output 101; seed 127 → 127.
- Hold findPrimeEnable high across the whole search, then add a second rising edge during TEST → exactly one result; the second edge is ignored; no retrigger on return to IDLE while the enable stays high.
- Assert rst during TEST of seed 90 → next cycle IDLE, outputs 0, primeValid never pulses; a new start after release behaves normally.
- WIDTH=4, seed 15 → wraps, output 2. With FIND_PRIME_CACHE_EN, seed 8 twice → second result 11 after 1 edge.
